// File: rtl/vending_machine_param.sv
// Parameterised coin-operated vending controller.
// Credit is counted in 5-rupee units. Coins of 1, 2 or 4 units are accepted
// while the machine is idle or accumulating; once the price is reached the
// product is released for one cycle and any surplus is paid back as a train
// of single-unit change pulses. A cancel while accumulating refunds all held
// credit through the same payout path.

module vending_machine_param #(
   parameter  int PRICE_UNITS = 3,                     // product price, >= 1
   parameter  int MAX_UNITS   = 8,                     // credit ceiling, >= PRICE_UNITS
   localparam int CW          = $clog2(MAX_UNITS + 1)  // credit counter width
) (
   input  logic          clk,
   input  logic          rst,          // synchronous, active low
   input  logic          coin_valid,
   input  logic [1:0]    coin_val,
   input  logic          cancel,
   output logic          dispense,
   output logic          change_5,
   output logic          coin_reject,
   output logic          busy,
   output logic [CW-1:0] credit
);

   // Sum width: one bit wider than the counter so credit + coin cannot wrap
   // before the ceiling compare, and never narrower than the largest coin
   // value (4 units needs 3 bits) for very small MAX_UNITS.
   localparam int SW = ((CW + 1) > 3) ? (CW + 1) : 3;

   localparam logic [SW-1:0] MAX_SUM   = SW'(MAX_UNITS);
   localparam logic [SW-1:0] PRICE_SUM = SW'(PRICE_UNITS);
   localparam logic [CW-1:0] PRICE_CR  = CW'(PRICE_UNITS);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,   // no credit held
      S_ACCUM  = 2'd1,   // 0 < credit < price
      S_VEND   = 2'd2,   // one-cycle product release
      S_PAYOUT = 2'd3    // one change pulse per held unit
   } state_e;

   state_e        state_q,  state_d;
   logic [CW-1:0] credit_q, credit_d;
   logic          reject_q, reject_d;

   logic [2:0]    coin_units;
   logic          coin_code_ok;
   logic [SW-1:0] credit_sum;
   logic          coin_fits;
   logic          coin_accept;

   // Decode the coin code and work out whether it would fit under the ceiling.
   always_comb begin
      // NOTE: every combinational output gets a default before the case so no
      // path leaves it unassigned, which would otherwise infer a latch.
      coin_units   = 3'd0;
      coin_code_ok = 1'b1;
      case (coin_val)
         2'b00:   coin_units = 3'd1;
         2'b01:   coin_units = 3'd2;
         2'b10:   coin_units = 3'd4;
         default: coin_code_ok = 1'b0;
      endcase
      credit_sum  = SW'(credit_q) + SW'(coin_units);
      coin_fits   = (credit_sum <= MAX_SUM);
      coin_accept = coin_valid && coin_code_ok && !cancel && coin_fits;
   end

   // Next-state, next-credit and reject-pulse logic.
   always_comb begin
      // NOTE: combinational blocks use blocking (=) assignments so later
      // statements see earlier results within the same evaluation.
      state_d  = state_q;
      credit_d = credit_q;
      reject_d = 1'b0;

      case (state_q)
         S_IDLE, S_ACCUM: begin
            if (coin_valid) begin
               if (coin_accept) begin
                  credit_d = CW'(credit_sum);
                  state_d  = (credit_sum >= PRICE_SUM) ? S_VEND : S_ACCUM;
               end else begin
                  reject_d = 1'b1;
               end
            end
            // Refund only makes sense with credit held; a cancel in IDLE
            // does nothing. A coin presented alongside cancel was rejected
            // above, so credit_d is still the held credit here.
            if (cancel && (state_q == S_ACCUM)) begin
               state_d = S_PAYOUT;
            end
         end

         S_VEND: begin
            reject_d = coin_valid;
            credit_d = credit_q - PRICE_CR;
            state_d  = (credit_q == PRICE_CR) ? S_IDLE : S_PAYOUT;
         end

         S_PAYOUT: begin
            reject_d = coin_valid;
            if (credit_q <= CW'(1)) begin
               credit_d = '0;
               state_d  = S_IDLE;
            end else begin
               credit_d = credit_q - CW'(1);
            end
         end

         // Unreachable with a full 2-bit encoding, but keeps recovery explicit
         // if the state register is ever corrupted.
         default: begin
            credit_d = '0;
            state_d  = S_IDLE;
         end
      endcase
   end

   // State, credit and reject registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking (<=) assignments so every
      // flop samples values from before the edge.
      if (!rst) begin
         state_q  <= S_IDLE;
         credit_q <= '0;
         reject_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         credit_q <= credit_d;
         reject_q <= reject_d;
      end
   end

   // Moore outputs from the state register; coin_reject is the registered
   // verdict on the previous cycle's coin.
   assign dispense    = (state_q == S_VEND);
   assign change_5    = (state_q == S_PAYOUT);
   assign busy        = (state_q == S_VEND) || (state_q == S_PAYOUT);
   assign credit      = credit_q;
   assign coin_reject = reject_q;

endmodule

// File: doc/vending_machine_param.md
VENDING_MACHINE_PARAM -- requirements
Module: vending_machine_param

Interface
REQ-001 The block SHALL have parameter PRICE_UNITS, default 3, giving the product price in 5-rupee units (default ₹15); legal range is PRICE_UNITS >= 1.
REQ-002 The block SHALL have parameter MAX_UNITS, default 8, giving the maximum credit held in 5-rupee units; legal range is MAX_UNITS >= PRICE_UNITS.
REQ-003 The block SHALL have localparam CW = $clog2(MAX_UNITS+1), the credit counter width.
REQ-004 clk  input  1  the single clock; all state changes on the rising edge.
REQ-005 rst  input  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
REQ-006 coin_valid  input  1  one-cycle strobe: a coin is presented this cycle.
REQ-007 coin_val  input  2  coin code, qualified by coin_valid: 00=₹5 (1 unit), 01=₹10 (2 units), 10=₹20 (4 units), 11=invalid.
REQ-008 cancel  input  1  one-cycle request to refund all held credit.
REQ-009 dispense  output  1  product release; high for exactly one cycle per vend.
REQ-010 change_5  output  1  releases one ₹5 coin per cycle in which it is high.
REQ-011 coin_reject  output  1  one-cycle pulse: the coin presented in the previous cycle was returned and not credited.
REQ-012 busy  output  1  high while vending or paying out; coins are not accepted.
REQ-013 credit  output  CW  current held credit in units; registered.

Function
REQ-014 FSM states SHALL be IDLE (credit==0), ACCUM (0<credit<PRICE_UNITS), VEND and PAYOUT; outputs SHALL be Moore except coin_reject.
REQ-015 Coin acceptance in IDLE/ACCUM: a coin is accepted when coin_valid=1, coin_val!=11, cancel=0 and credit+units <= MAX_UNITS; on acceptance credit <= credit+units at the next edge.
REQ-016 Rejection: coin_valid=1 with coin_val=11, with the sum > MAX_UNITS, with cancel=1 in the same cycle, or in VEND/PAYOUT SHALL leave credit unchanged and assert coin_reject in the following cycle only.
REQ-017 After an accepted coin: next state is VEND if new credit >= PRICE_UNITS, else ACCUM. Sum arithmetic SHALL be CW+1 bits wide so no overflow occurs before the compare.
REQ-018 VEND SHALL last exactly one cycle with dispense=1 and busy=1; at its exit edge credit <= credit-PRICE_UNITS. Next state is PAYOUT if the remainder > 0, else IDLE.
REQ-019 PAYOUT: change_5=1 and busy=1 in every cycle; credit decrements by 1 per cycle. On the edge where credit goes 1->0 the next state is IDLE, giving exactly N consecutive change_5 cycles for N held units.
REQ-020 cancel in ACCUM SHALL move to PAYOUT (full refund, no dispense); cancel in IDLE, VEND or PAYOUT SHALL be ignored.
REQ-021 Latency: a coin completing the price at cycle N SHALL produce dispense in cycle N+1 and the first change_5 in cycle N+2.
REQ-022 dispense and change_5 SHALL never be high in the same cycle; busy = (state==VEND)||(state==PAYOUT).
REQ-023 Illegal state encodings SHALL return to IDLE at the next edge, with credit cleared.

Reset
REQ-024 When rst=0 at a rising edge, state SHALL become IDLE and credit SHALL become 0; in the following cycle dispense, change_5, coin_reject and busy SHALL all be 0.
REQ-025 Reset asserted mid-VEND or mid-PAYOUT SHALL abort the operation; any pending change is discarded and no further pulses are emitted.
REQ-026 Inputs in the reset cycle SHALL be ignored, and no coin_reject SHALL be generated for them.

Verification
REQ-027 Defaults: ₹5, then ₹10 on the next cycle -> credit 1 then 3, dispense one cycle, no change_5, return to IDLE with credit 0.
REQ-028 Defaults: ₹10, then ₹20 -> credit 6, dispense one cycle, then change_5 for exactly 3 consecutive cycles, then IDLE.
REQ-029 Defaults: ₹5, then cancel -> one change_5 cycle, no dispense, credit 0; cancel in IDLE -> no output activity.
REQ-030 Coin during busy, or coin_val=11, or coin_valid together with cancel -> coin_reject one cycle later, credit unaffected by the coin.
REQ-031 PRICE_UNITS=5, MAX_UNITS=6: ₹20 (4 units), then ₹20 -> second coin rejected, credit stays 4; then ₹10 -> credit 6, dispense, 1 change_5.
REQ-032 rst=0 during the second change_5 cycle of the REQ-028 scenario -> next cycle all outputs 0 and credit 0; no further change_5.
